// File: rtl/l15_port_arbiter.sv
// N-channel arbiter sharing the single L1.5 transducer port between core requesters.
// Define L15_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module l15_port_arbiter #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH*5-1:0]      ch_rqtype,
   input  logic [NUM_CH*3-1:0]      ch_size,
   input  logic [NUM_CH*ADDR_W-1:0] ch_address,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic [NUM_CH-1:0]        ch_val,
   output logic [NUM_CH-1:0]        ch_ack,
   output logic [NUM_CH-1:0]        ch_header_ack,
   output logic [NUM_CH-1:0]        ch_resp_val,
   output logic [63:0]              ch_resp_data_0,
   output logic [63:0]              ch_resp_data_1,
   output logic [3:0]               ch_resp_returntype,
   input  logic [NUM_CH-1:0]        ch_req_ack,
   output logic [4:0]               transducer_l15_rqtype,
   output logic [2:0]               transducer_l15_size,
   output logic [ADDR_W-1:0]        transducer_l15_address,
   output logic [DATA_W-1:0]        transducer_l15_data,
   output logic                     transducer_l15_val,
   input  logic                     l15_transducer_ack,
   input  logic                     l15_transducer_header_ack,
   input  logic                     l15_transducer_val,
   input  logic [63:0]              l15_transducer_data_0,
   input  logic [63:0]              l15_transducer_data_1,
   input  logic [3:0]               l15_transducer_returntype,
   output logic                     transducer_l15_req_ack,
   output logic [IDW-1:0]           grant_id,
   output logic                     busy
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t state, next_state;

   logic [IDW-1:0]    winner;
   logic              take;
   logic [NUM_CH-1:0] owner_hot;
   logic              own_val;
   logic              own_req_ack;
   logic [4:0]        own_rqtype;
   logic [2:0]        own_size;
   logic [ADDR_W-1:0] own_address;
   logic [DATA_W-1:0] own_data;

   assign take = (state == IDLE) && (|ch_val);
   assign busy = (state != IDLE);

`ifdef L15_ARB_RR_EN
   logic [IDW-1:0] rr_ptr;
   logic           found;

   // First requester above the pointer, else wrap to the lowest one.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && ch_val[i] && (IDW'(i) > rr_ptr)) begin
            winner = IDW'(i);
            found  = 1'b1;
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && ch_val[i]) begin
            winner = IDW'(i);
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= IDW'(NUM_CH - 1);
      else if (take)
         rr_ptr <= winner;
   end
`else
   always_comb begin
      winner = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_val[i])
            winner = IDW'(i);
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         grant_id <= '0;
      end else begin
         state <= next_state;
         if (take)
            grant_id <= winner;
      end
   end

   always_comb begin
      owner_hot   = '0;
      own_val     = 1'b0;
      own_req_ack = 1'b0;
      own_rqtype  = '0;
      own_size    = '0;
      own_address = '0;
      own_data    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_id == IDW'(i)) begin
            owner_hot[i] = 1'b1;
            own_val      = ch_val[i];
            own_req_ack  = ch_req_ack[i];
            own_rqtype   = ch_rqtype[5*i +: 5];
            own_size     = ch_size[3*i +: 3];
            own_address  = ch_address[ADDR_W*i +: ADDR_W];
            own_data     = ch_data[DATA_W*i +: DATA_W];
         end
      end
   end

   always_comb begin
      ch_resp_data_0     = l15_transducer_val ? l15_transducer_data_0 : '0;
      ch_resp_data_1     = l15_transducer_val ? l15_transducer_data_1 : '0;
      ch_resp_returntype = l15_transducer_val ? l15_transducer_returntype : '0;
   end

   always_comb begin
      next_state             = state;
      ch_ack                 = '0;
      ch_header_ack          = '0;
      ch_resp_val            = '0;
      transducer_l15_val     = 1'b0;
      transducer_l15_rqtype  = '0;
      transducer_l15_size    = '0;
      transducer_l15_address = '0;
      transducer_l15_data    = '0;
      transducer_l15_req_ack = 1'b0;
      unique case (state)
         IDLE: begin
            ch_resp_val[0]         = l15_transducer_val;
            transducer_l15_req_ack = l15_transducer_val & ch_req_ack[0];
            if (|ch_val)
               next_state = REQ;
         end
         REQ: begin
            transducer_l15_val     = own_val;
            transducer_l15_rqtype  = own_rqtype;
            transducer_l15_size    = own_size;
            transducer_l15_address = own_address;
            transducer_l15_data    = own_data;
            ch_ack        = owner_hot & {NUM_CH{l15_transducer_ack}};
            ch_header_ack = owner_hot & {NUM_CH{l15_transducer_header_ack}};
            // A response arriving before our ack is not ours: hand it to fetch.
            ch_resp_val[0]         = l15_transducer_val;
            transducer_l15_req_ack = l15_transducer_val & ch_req_ack[0];
            if (l15_transducer_ack)
               next_state = RESP;
            else if (!own_val)
               next_state = IDLE;
         end
         RESP: begin
            ch_resp_val            = owner_hot & {NUM_CH{l15_transducer_val}};
            transducer_l15_req_ack = own_req_ack;
            if (l15_transducer_val && own_req_ack)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_l15_port_arbiter.sv
// Bench for l15_port_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_l15_port_arbiter;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*5-1:0] ch_rqtype;
   logic [N*3-1:0] ch_size;
   logic [N*32-1:0] ch_address;
   logic [N*32-1:0] ch_data;
   logic [N-1:0]   ch_val;
   logic [N-1:0]   ch_ack;
   logic [N-1:0]   ch_header_ack;
   logic [N-1:0]   ch_resp_val;
   logic [63:0]    ch_resp_data_0;
   logic [63:0]    ch_resp_data_1;
   logic [3:0]     ch_resp_returntype;
   logic [N-1:0]   ch_req_ack;
   logic [4:0]     transducer_l15_rqtype;
   logic [2:0]     transducer_l15_size;
   logic [31:0]    transducer_l15_address;
   logic [31:0]    transducer_l15_data;
   logic           transducer_l15_val;
   logic           l15_transducer_ack;
   logic           l15_transducer_header_ack;
   logic           l15_transducer_val;
   logic [63:0]    l15_transducer_data_0;
   logic [63:0]    l15_transducer_data_1;
   logic [3:0]     l15_transducer_returntype;
   logic           transducer_l15_req_ack;
   logic [1:0]     grant_id;
   logic           busy;

   l15_port_arbiter #(.NUM_CH(N), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk),
      .rst(rst),
      .ch_rqtype(ch_rqtype),
      .ch_size(ch_size),
      .ch_address(ch_address),
      .ch_data(ch_data),
      .ch_val(ch_val),
      .ch_ack(ch_ack),
      .ch_header_ack(ch_header_ack),
      .ch_resp_val(ch_resp_val),
      .ch_resp_data_0(ch_resp_data_0),
      .ch_resp_data_1(ch_resp_data_1),
      .ch_resp_returntype(ch_resp_returntype),
      .ch_req_ack(ch_req_ack),
      .transducer_l15_rqtype(transducer_l15_rqtype),
      .transducer_l15_size(transducer_l15_size),
      .transducer_l15_address(transducer_l15_address),
      .transducer_l15_data(transducer_l15_data),
      .transducer_l15_val(transducer_l15_val),
      .l15_transducer_ack(l15_transducer_ack),
      .l15_transducer_header_ack(l15_transducer_header_ack),
      .l15_transducer_val(l15_transducer_val),
      .l15_transducer_data_0(l15_transducer_data_0),
      .l15_transducer_data_1(l15_transducer_data_1),
      .l15_transducer_returntype(l15_transducer_returntype),
      .transducer_l15_req_ack(transducer_l15_req_ack),
      .grant_id(grant_id),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_chk++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   // Transaction-level model: phase 0 idle, 1 request issued, 2 awaiting response
   int m_phase = 0;
   int m_owner = 0;
   int m_ptr   = N - 1;

   function automatic int pick(input logic [N-1:0] v, input int ptr);
      int p;
      p = ptr;
`ifdef L15_ARB_RR_EN
      for (int k = 1; k <= N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
`else
      p = 0;
      for (int k = p; k < N; k++)
         if (v[k]) return k;
`endif
      return 0;
   endfunction

   logic [N-1:0] e_ack, e_hack, e_rv;
   logic         e_tval, e_rqack;
   logic [4:0]   e_rq;
   logic [2:0]   e_sz;
   logic [31:0]  e_addr, e_data;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_busy", 64'(busy), 64'(0));
         chk("rst_gid", 64'(grant_id), 64'(0));
         chk("rst_tval", 64'(transducer_l15_val), 64'(0));
         chk("rst_addr", 64'(transducer_l15_address), 64'(0));
         chk("rst_ack", 64'(ch_ack), 64'(0));
         chk("rst_rv", 64'(ch_resp_val), 64'(0));
         chk("rst_rqack", 64'(transducer_l15_req_ack), 64'(0));
         m_phase = 0;
         m_owner = 0;
         m_ptr   = N - 1;
      end else begin
         e_ack = '0; e_hack = '0; e_rv = '0;
         e_tval = 1'b0; e_rq = '0; e_sz = '0; e_addr = '0; e_data = '0;
         if (m_phase == 1) begin
            e_tval = ch_val[m_owner];
            e_rq   = ch_rqtype[m_owner*5 +: 5];
            e_sz   = ch_size[m_owner*3 +: 3];
            e_addr = ch_address[m_owner*32 +: 32];
            e_data = ch_data[m_owner*32 +: 32];
            e_ack[m_owner]  = l15_transducer_ack;
            e_hack[m_owner] = l15_transducer_header_ack;
         end
         if (m_phase == 2) begin
            e_rv[m_owner] = l15_transducer_val;
            e_rqack = ch_req_ack[m_owner];
         end else begin
            e_rv[0] = l15_transducer_val;
            e_rqack = l15_transducer_val & ch_req_ack[0];
         end
         chk("busy", 64'(busy), 64'(m_phase != 0));
         chk("grant_id", 64'(grant_id), 64'(m_owner));
         chk("tval", 64'(transducer_l15_val), 64'(e_tval));
         chk("rqtype", 64'(transducer_l15_rqtype), 64'(e_rq));
         chk("size", 64'(transducer_l15_size), 64'(e_sz));
         chk("address", 64'(transducer_l15_address), 64'(e_addr));
         chk("data", 64'(transducer_l15_data), 64'(e_data));
         chk("ch_ack", 64'(ch_ack), 64'(e_ack));
         chk("ch_header_ack", 64'(ch_header_ack), 64'(e_hack));
         chk("ch_resp_val", 64'(ch_resp_val), 64'(e_rv));
         chk("req_ack", 64'(transducer_l15_req_ack), 64'(e_rqack));
         chk("resp_d0", ch_resp_data_0, l15_transducer_val ? l15_transducer_data_0 : 64'(0));
         chk("resp_d1", ch_resp_data_1, l15_transducer_val ? l15_transducer_data_1 : 64'(0));
         chk("resp_rt", 64'(ch_resp_returntype),
             64'(l15_transducer_val ? l15_transducer_returntype : 4'(0)));
         case (m_phase)
            0: if (|ch_val) begin
                  m_owner = pick(ch_val, m_ptr);
                  m_ptr   = m_owner;
                  m_phase = 1;
               end
            1: if (l15_transducer_ack) m_phase = 2;
               else if (!ch_val[m_owner]) m_phase = 0;
            default: if (l15_transducer_val && ch_req_ack[m_owner]) m_phase = 0;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      ch_val = '0;
      ch_req_ack = '0;
      l15_transducer_ack = 1'b0;
      l15_transducer_header_ack = 1'b0;
      l15_transducer_val = 1'b0;
   endtask

   task automatic do_reset();
      tick();
      clear();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_busy(input logic want);
      @(negedge clk);
      for (int k = 0; k < 16 && busy !== want; k++)
         @(negedge clk);
      chk("wait_busy", 64'(busy), 64'(want));
   endtask

   int exp_cont[5];
   logic [N-1:0] ackd;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      ch_rqtype = '0; ch_size = '0; ch_address = '0; ch_data = '0;
      l15_transducer_data_0 = '0; l15_transducer_data_1 = '0;
      l15_transducer_returntype = '0;
      clear();
      repeat (2) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_gid", 64'(grant_id), 64'(0));
      tick();
      rst = 1'b0;

      // single request from channel 1
      tick();
      ch_val = 4'b0010;
      ch_address[63:32] = 32'h100;
      ch_rqtype[9:5] = 5'd1;
      tick();
      @(negedge clk);
      chk("single_addr", 64'(transducer_l15_address), 64'h100);
      chk("single_tval", 64'(transducer_l15_val), 64'(1));
      chk("single_gid", 64'(grant_id), 64'(1));
      tick();
      tick();
      l15_transducer_ack = 1'b1;
      @(negedge clk);
      chk("single_ack", 64'(ch_ack), 64'(4'b0010));
      tick();
      l15_transducer_ack = 1'b0;
      ch_val = '0;
      tick();
      tick();
      tick();
      l15_transducer_val = 1'b1;
      l15_transducer_data_0 = 64'h0123_4567_89ab_cdef;
      ch_req_ack = 4'b0010;
      @(negedge clk);
      chk("single_rv", 64'(ch_resp_val), 64'(4'b0010));
      chk("single_rqack", 64'(transducer_l15_req_ack), 64'(1));
      tick();
      clear();
      @(negedge clk);
      chk("single_idle", 64'(busy), 64'(0));

      // contention with every channel requesting continuously
`ifdef L15_ARB_RR_EN
      exp_cont = '{0, 1, 2, 3, 0};
`else
      exp_cont = '{0, 0, 0, 0, 0};
`endif
      do_reset();
      ch_val = 4'b1111;
      ch_req_ack = 4'b1111;
      l15_transducer_ack = 1'b1;
      l15_transducer_val = 1'b1;
      for (int t = 0; t < 5; t++) begin
         wait_busy(1'b1);
         chk("cont_gid", 64'(grant_id), 64'(exp_cont[t]));
         wait_busy(1'b0);
      end
      do_reset();

      // unsolicited response while channel 2 waits in REQ
      tick();
      ch_val = 4'b0100;
      wait_busy(1'b1);
      chk("unsol_gid0", 64'(grant_id), 64'(2));
      tick();
      l15_transducer_val = 1'b1;
      l15_transducer_data_0 = 64'hdead_beef_0123_4567;
      ch_req_ack = 4'b0001;
      @(negedge clk);
      chk("unsol_rv", 64'(ch_resp_val), 64'(4'b0001));
      chk("unsol_rqack", 64'(transducer_l15_req_ack), 64'(1));
      chk("unsol_d0", ch_resp_data_0, 64'hdead_beef_0123_4567);
      chk("unsol_gid", 64'(grant_id), 64'(2));
      tick();
      l15_transducer_val = 1'b0;
      ch_req_ack = '0;
      l15_transducer_ack = 1'b1;
      @(negedge clk);
      chk("unsol_ack", 64'(ch_ack), 64'(4'b0100));
      tick();
      l15_transducer_ack = 1'b0;
      ch_val = '0;
      l15_transducer_val = 1'b1;
      ch_req_ack = 4'b0100;
      @(negedge clk);
      chk("unsol_own_rv", 64'(ch_resp_val), 64'(4'b0100));
      tick();
      clear();
      @(negedge clk);
      chk("unsol_idle", 64'(busy), 64'(0));

      // abort: owner drops its request before the ack
      do_reset();
      tick();
      ch_val = 4'b0010;
      wait_busy(1'b1);
      tick();
      ch_val = '0;
      @(negedge clk);
      chk("abort_ack", 64'(ch_ack), 64'(0));
      tick();
      @(negedge clk);
      chk("abort_idle", 64'(busy), 64'(0));
      tick();
      ch_val = 4'b1111;
      wait_busy(1'b1);
`ifdef L15_ARB_RR_EN
      chk("abort_next_gid", 64'(grant_id), 64'(2));
`else
      chk("abort_next_gid", 64'(grant_id), 64'(0));
`endif
      do_reset();

      // reset while waiting for a response
      tick();
      ch_val = 4'b1000;
      wait_busy(1'b1);
      tick();
      l15_transducer_ack = 1'b1;
      tick();
      l15_transducer_ack = 1'b0;
      ch_val = '0;
      @(negedge clk);
      chk("rstresp_busy", 64'(busy), 64'(1));
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rstresp_busy0", 64'(busy), 64'(0));
      chk("rstresp_rv", 64'(ch_resp_val), 64'(0));
      tick();
      rst = 1'b0;
      tick();
      l15_transducer_val = 1'b1;
      ch_req_ack = 4'b0001;
      @(negedge clk);
      chk("rstresp_late_rv", 64'(ch_resp_val), 64'(4'b0001));
      chk("rstresp_late_rqack", 64'(transducer_l15_req_ack), 64'(1));
      tick();
      clear();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         ackd = ch_ack;
         tick();
         for (int i = 0; i < N; i++) begin
            if (ch_val[i] && ackd[i])
               ch_val[i] = 1'b0;
            else if (ch_val[i] && $urandom_range(0, 39) == 0)
               ch_val[i] = 1'b0;
            else if (!ch_val[i] && $urandom_range(0, 2) == 0) begin
               ch_rqtype[i*5 +: 5] = 5'($urandom());
               ch_size[i*3 +: 3] = 3'($urandom());
               ch_address[i*32 +: 32] = $urandom();
               ch_data[i*32 +: 32] = $urandom();
               ch_val[i] = 1'b1;
            end
         end
         l15_transducer_ack = ($urandom_range(0, 2) == 0);
         l15_transducer_header_ack = ($urandom_range(0, 2) == 0);
         l15_transducer_val = ($urandom_range(0, 3) == 0);
         l15_transducer_data_0 = {$urandom(), $urandom()};
         l15_transducer_data_1 = {$urandom(), $urandom()};
         l15_transducer_returntype = 4'($urandom());
         ch_req_ack = 4'($urandom_range(0, 15));
      end
      tick();
      clear();
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
